// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_sub_structural.sv
// 1-bit full subtractor cell, gate level: d = a - b - bin, bout set when the bit underflows.
module full_sub_structural (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic axb;
   logic axb_n;
   logic a_n;
   logic t_ab;
   logic t_bin;

   xor u_x1 (axb, a, b);
   xor u_x2 (d, axb, bin);
   not u_n1 (a_n, a);
   not u_n2 (axb_n, axb);
   and u_g1 (t_ab, a_n, b);
   and u_g2 (t_bin, axb_n, bin);
   or  u_o1 (bout, t_ab, t_bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: one shared full-subtractor cell walks the operands LSB first.
// Start accepted in IDLE only; result lands WIDTH edges later with a one-cycle done pulse.
module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy_out,
   output logic             done_out,
   output logic [WIDTH-1:0] diff_out,
   output logic             borrow_out
);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] d_sr;
   logic [WIDTH-1:0] d_sr_next;
   logic             borrow;
   logic [CNT_W-1:0] cnt;
   logic             cell_d;
   logic             cell_bout;
   logic             last_bit;

   full_sub_structural u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (borrow),
      .d    (cell_d),
      .bout (cell_bout)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // New diff bit enters at the MSB so the LSB-first stream ends up in place after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_w1
         assign d_sr_next = cell_d;
      end else begin : g_wn
         assign d_sr_next = {cell_d, d_sr[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start_in) state_next = ST_RUN;
         ST_RUN:  if (last_bit) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   assign busy_out = (state == ST_RUN) || (state == ST_DONE);
   assign done_out = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr       <= '0;
         b_sr       <= '0;
         d_sr       <= '0;
         borrow     <= 1'b0;
         cnt        <= '0;
         diff_out   <= '0;
         borrow_out <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_in) begin
                  a_sr   <= a_in;
                  b_sr   <= b_in;
                  borrow <= 1'b0;
                  cnt    <= '0;
               end
            end
            ST_RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               d_sr   <= d_sr_next;
               borrow <= cell_bout;
               cnt    <= cnt + CNT_W'(1);
               // Result registers only move here, so they hold across later starts.
               if (last_bit) begin
                  diff_out   <= d_sr_next;
                  borrow_out <= cell_bout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random checks of serial_sub_ctrl at widths 8, 13 and 1.
module tb_serial_sub_ctrl;

   logic clk;
   logic rst_n;

   logic        start8, busy8, done8, bo8;
   logic [7:0]  a8, b8, diff8;
   logic        start13, busy13, done13, bo13;
   logic [12:0] a13, b13, diff13;
   logic        start1, busy1, done1, bo1;
   logic [0:0]  a1, b1, diff1;

   int checks = 0;
   int errors = 0;

   serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start_in(start8), .a_in(a8), .b_in(b8),
      .busy_out(busy8), .done_out(done8), .diff_out(diff8), .borrow_out(bo8)
   );

   serial_sub_ctrl #(.WIDTH(13)) u_dut13 (
      .clk(clk), .rst_n(rst_n), .start_in(start13), .a_in(a13), .b_in(b13),
      .busy_out(busy13), .done_out(done13), .diff_out(diff13), .borrow_out(bo13)
   );

   serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start_in(start1), .a_in(a1), .b_in(b1),
      .busy_out(busy1), .done_out(done1), .diff_out(diff1), .borrow_out(bo1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          w;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_d;
      logic        exp_bo;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_in(input int w, input logic [31:0] a, input logic [31:0] b, input logic s);
      case (w)
         8:  begin a8  = a[7:0];  b8  = b[7:0];  start8  = s; end
         13: begin a13 = a[12:0]; b13 = b[12:0]; start13 = s; end
         default: begin a1 = a[0:0]; b1 = b[0:0]; start1 = s; end
      endcase
   endtask

   function automatic logic get_done(input int w);
      case (w)
         8:       return done8;
         13:      return done13;
         default: return done1;
      endcase
   endfunction

   function automatic logic get_busy(input int w);
      case (w)
         8:       return busy8;
         13:      return busy13;
         default: return busy1;
      endcase
   endfunction

   function automatic logic get_bo(input int w);
      case (w)
         8:       return bo8;
         13:      return bo13;
         default: return bo1;
      endcase
   endfunction

   function automatic logic [31:0] get_diff(input int w);
      case (w)
         8:       return {24'd0, diff8};
         13:      return {19'd0, diff13};
         default: return {31'd0, diff1};
      endcase
   endfunction

   // One full operation from an idle DUT, checking latency, busy, result hold and result.
   task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic exp_bo, input string tag);
      logic [31:0] prev_d;
      int          k;
      bit          got;
      @(negedge clk);
      prev_d = get_diff(w);
      set_in(w, a, b, 1'b1);
      @(posedge clk);
      #1;
      set_in(w, a, b, 1'b0);
      chk({tag, " busy_after_start"}, {31'd0, get_busy(w)}, 32'd1);
      chk({tag, " result_hold"}, get_diff(w), prev_d);
      k   = 0;
      got = 1'b0;
      while (!got && k < w + 4) begin
         @(posedge clk);
         #1;
         k++;
         if (get_done(w)) got = 1'b1;
      end
      chk({tag, " done_seen"}, {31'd0, got}, 32'd1);
      chk({tag, " latency"}, k, w);
      chk({tag, " diff"}, get_diff(w), exp_d);
      chk({tag, " borrow"}, {31'd0, get_bo(w)}, {31'd0, exp_bo});
      chk({tag, " busy_in_done"}, {31'd0, get_busy(w)}, 32'd1);
      @(posedge clk);
      #1;
      chk({tag, " done_one_cycle"}, {31'd0, get_done(w)}, 32'd0);
      chk({tag, " idle_after_done"}, {31'd0, get_busy(w)}, 32'd0);
   endtask

   vec_t vecs[$];

   initial begin
      int          pulses;
      logic [31:0] ra, rb, mask, ed;
      logic        eb;

      vecs.push_back('{8, 100, 37, 63, 1'b0});
      vecs.push_back('{8, 5, 10, 251, 1'b1});
      vecs.push_back('{8, 0, 1, 255, 1'b1});
      vecs.push_back('{8, 255, 255, 0, 1'b0});
      vecs.push_back('{8, 128, 1, 127, 1'b0});
      vecs.push_back('{8, 0, 255, 1, 1'b1});
      vecs.push_back('{13, 8191, 1, 8190, 1'b0});
      vecs.push_back('{13, 0, 8191, 1, 1'b1});
      vecs.push_back('{1, 1, 1, 0, 1'b0});
      vecs.push_back('{1, 0, 1, 1, 1'b1});
      vecs.push_back('{1, 1, 0, 1, 1'b0});
      vecs.push_back('{1, 0, 0, 0, 1'b0});

      rst_n = 1'b0;
      set_in(8, 0, 0, 1'b0);
      set_in(13, 0, 0, 1'b0);
      set_in(1, 0, 0, 1'b0);
      #1;
      chk("reset busy", {31'd0, busy8}, 32'd0);
      chk("reset done", {31'd0, done8}, 32'd0);
      chk("reset diff", {24'd0, diff8}, 32'd0);
      chk("reset borrow", {31'd0, bo8}, 32'd0);
      chk("reset diff13", {19'd0, diff13}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i])
         run_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_bo,
                $sformatf("vec%0d", i));

      // Start held high through RUN/DONE, a_in disturbed mid-run: second op picks up a=9 at E10.
      @(negedge clk);
      set_in(8, 100, 37, 1'b1);
      @(posedge clk);
      pulses = 0;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk);
         #1;
         if (n == 3) a8 = 8'd9;
         if (n == 10) start8 = 1'b0;
         if (done8) begin
            pulses++;
            if (pulses == 1) begin
               chk("held first_cycle", n, 8);
               chk("held first_diff", {24'd0, diff8}, 32'd63);
               chk("held first_borrow", {31'd0, bo8}, 32'd0);
            end else begin
               chk("held second_cycle", n, 18);
               chk("held second_diff", {24'd0, diff8}, 32'd228);
               chk("held second_borrow", {31'd0, bo8}, 32'd1);
            end
         end
      end
      chk("held pulse_count", pulses, 2);

      // Reset in the middle of a 200-1 operation.
      @(negedge clk);
      set_in(8, 200, 1, 1'b1);
      @(posedge clk);
      #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst busy", {31'd0, busy8}, 32'd0);
      chk("midrst done", {31'd0, done8}, 32'd0);
      chk("midrst diff", {24'd0, diff8}, 32'd0);
      chk("midrst borrow", {31'd0, bo8}, 32'd0);
      pulses = 0;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk);
         #1;
         if (done8) pulses++;
         if (n == 2) rst_n = 1'b1;
      end
      chk("midrst no_done", pulses, 0);
      run_op(8, 20, 3, 17, 1'b0, "after_rst");

      for (int i = 0; i < 1000; i++) begin
         mask = 32'hFF;
         ra = $urandom & mask;
         rb = $urandom & mask;
         ed = (ra - rb) & mask;
         eb = (ra < rb);
         run_op(8, ra, rb, ed, eb, $sformatf("rnd8_%0d", i));
      end
      for (int i = 0; i < 1000; i++) begin
         mask = 32'h1FFF;
         ra = $urandom & mask;
         rb = $urandom & mask;
         ed = (ra - rb) & mask;
         eb = (ra < rb);
         run_op(13, ra, rb, ed, eb, $sformatf("rnd13_%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial WIDTH-bit unsigned subtractor (a − b). It time-shares one 1-bit full subtractor cell across all bit positions, LSB first. A controller FSM sequences the cell with operand shift registers, a borrow flip-flop and a bit counter. It sits beside the combinational subtractor library as the low-area alternative, driven by a start/done handshake.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start_in  input  1  request pulse/level; sampled only in IDLE
a_in  input  WIDTH  minuend; captured on the accepting edge
b_in  input  WIDTH  subtrahend; captured on the accepting edge
busy_out  output  1  high in RUN and DONE
done_out  output  1  one-cycle pulse; result valid
diff_out  output  WIDTH  registered a − b mod 2^WIDTH
borrow_out  output  1  registered final borrow (1 ⇔ a < b unsigned)

Behaviour:
- Reset is asynchronous active-low, per the already-decided clocking; clk/rst_n are the only clock/reset.
  - rst_n=0 immediately forces: state=IDLE, busy_out=0, done_out=0, diff_out=0, borrow_out=0, shift regs=0, borrow FF=0, counter=0.
  - Deassertion takes effect on the next rising edge.
- FSM states: IDLE, RUN, DONE.
- IDLE, start_in=1 at an edge:
  - Capture a_in → a_sr and b_in → b_sr; clear borrow FF and counter; go to RUN.
  - No other register changes; diff_out/borrow_out keep the previous result.
- RUN, one bit per edge:
  - Cell inputs: a_sr[0], b_sr[0], borrow FF.
  - Cell diff bit shifts into d_sr at the MSB; d_sr shifts right.
  - Cell borrow → borrow FF; a_sr and b_sr shift right, zero-filled; counter increments.
  - When counter == WIDTH−1 at an edge: load diff_out ← final d_sr value (including this bit) and borrow_out ← this bit's borrow; go to DONE.
- DONE: done_out=1 for exactly one cycle; next edge → IDLE.
- Outputs: done_out and busy_out are decoded from the registered state (glitch-free, no combinational path from inputs).
- Latency: start accepted at edge E0; done_out high in the cycle after edge E_WIDTH; busy_out high from E0 to E_(WIDTH+1).
- Throughput: one operation per WIDTH+2 cycles.
- start_in during RUN or DONE is ignored and not queued. A level held high starts a new operation on the first edge back in IDLE.
- a_in/b_in changes after the accepting edge have no effect.
- Result hold: diff_out/borrow_out change only at RUN→DONE; they hold until the next completion or reset.
- Arithmetic: modulo 2^WIDTH, no sign interpretation. Borrow-in to bit 0 is always 0.
- WIDTH=1: RUN lasts one cycle; done_out in the cycle after E1.
- Reset mid-RUN: the operation is aborted with no done_out. The result clears to 0, not to a partial value.

Decomposition:
- Shared package serial_sub_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the default width constant.
- One sub-module: full_sub_structural (existing 1-bit full subtractor) instantiated once as the bit cell.
- FSM, counter and shift registers stay in serial_sub_ctrl.

Test Plan:
- WIDTH=8, a=100, b=37, start pulse at E0 → done_out high only after E8; diff_out=63, borrow_out=0; busy_out high E0..E9.
- a=5, b=10 → diff_out=251, borrow_out=1; a=0, b=1 → 255, borrow 1; a=255, b=255 → 0, borrow 0.
- Complete a=100, b=37, then hold start_in=1 through RUN/DONE with a_in changed to 9 mid-RUN:
  - first result still 63;
  - second operation starts at E10 with the values then on a_in/b_in;
  - exactly two done_out pulses.
- Assert rst_n=0 at E4 of a 200−1 operation → outputs zero immediately, no done_out; after release, 20−3 gives 17.
- WIDTH=1: 1−1 → 0/0; 0−1 → 1/1; done_out after E1.
- Random 1000 pairs at WIDTH=8 and WIDTH=13, compared against a reference model computing (a−b) mod 2^WIDTH and a<b.
